// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller that sits beside the ID-stage control unit.
// It keeps its own pipeline of destination tags for the DEPTH stages after ID (1=EXE, 2=MEM, 3=WB...).
// From those tags it produces the operand forwarding selects, load-use stalls and the stage-1 bubble.
// It also holds a scoreboard for one multi-cycle MUL/DIV unit whose result arrives MD_LAT cycles after issue.
//
// Ports:
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   id_valid, flush         ID holds an instruction / the ID instruction is killed (taken branch/jump)
//   id_rs, id_rt            source registers; id_use_rs and id_use_rt say whether each one is read
//   id_wreg, id_m2reg       ID instruction writes the register file / ID instruction is a load
//   id_rn, id_md_start      destination register / ID instruction issues a MUL/DIV into id_rn
//   fwda, fwdb              0 = register file, k = result of stage k (rs and rt respectively)
//   fwda_ld, fwdb_ld        the selected stage-k entry is a load, so the memory data is muxed
//   wpcir                   0 = hold the PC and the IF/ID register (stall)
//   bubble                  stage-1 tag loaded invalid this cycle
//   md_busy, md_done, md_rn MUL/DIV in flight / one-cycle result-ready pulse / in-flight destination
//   stall_cnt               only when HAZ_PERF_CNT_EN is defined: saturating count of stall cycles
//
// Configuration macro: HAZ_PERF_CNT_EN (adds the stall_cnt port and counter).
// fwd*, fwd*_ld, wpcir, bubble and md_busy are combinational; md_done and md_rn come from flops.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned MD_LAT = 4,
    localparam int unsigned FW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_rn,
    input  logic              id_md_start,
    output logic [FW-1:0]     fwda,
    output logic              fwda_ld,
    output logic [FW-1:0]     fwdb,
    output logic              fwdb_ld,
    output logic              wpcir,
    output logic              bubble,
    output logic              md_busy,
    output logic              md_done,
    output logic [REG_AW-1:0] md_rn
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned CW = 4;

    logic [DEPTH-1:0]  tag_v_q, tag_v_d;
    logic [DEPTH-1:0]  tag_wreg_q, tag_wreg_d;
    logic [DEPTH-1:0]  tag_m2reg_q, tag_m2reg_d;
    logic [REG_AW-1:0] tag_rn_q [DEPTH];
    logic [REG_AW-1:0] tag_rn_d [DEPTH];

    logic [CW-1:0]     md_cnt_q, md_cnt_d;
    logic [REG_AW-1:0] md_rn_q, md_rn_d;
    logic              md_done_q, md_done_d;

    logic              lu_a, lu_b;
    logic              md_raw, md_waw, md_str;
    logic              stall, fire;

    // Lowest matching stage wins; a stage-1 load cannot be forwarded and flags load-use instead.
    // Result packing: {load_use, sel_is_load, sel}.
    function automatic logic [FW+1:0] pick_fwd(input logic use_r, input logic [REG_AW-1:0] r);
        logic [FW+1:0] res;
        res = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (use_r && (r != '0) && tag_v_q[i] && tag_wreg_q[i] && (tag_rn_q[i] == r)) begin
                if (i == 0) begin
                    res = tag_m2reg_q[0] ? {1'b1, 1'b0, FW'(0)} : {1'b0, 1'b0, FW'(1)};
                end else begin
                    res = {1'b0, tag_m2reg_q[i], FW'(i + 1)};
                end
            end
        end
        return res;
    endfunction

    // Forwarding selects, stall decision and bubble.
    always_comb begin
        {lu_a, fwda_ld, fwda} = pick_fwd(id_use_rs, id_rs);
        {lu_b, fwdb_ld, fwdb} = pick_fwd(id_use_rt, id_rt);

        md_busy = (md_cnt_q != '0);
        md_raw  = md_busy && ((id_use_rs && (id_rs != '0) && (id_rs == md_rn_q)) ||
                              (id_use_rt && (id_rt != '0) && (id_rt == md_rn_q)));
        md_waw  = md_busy && (id_wreg || id_md_start) && (id_rn == md_rn_q);
        md_str  = md_busy && id_md_start;

        // A flush kills the ID instruction, so it never stalls.
        stall  = id_valid && !flush && (lu_a || lu_b || md_raw || md_waw || md_str);
        wpcir  = !stall;
        fire   = id_valid && !flush && !stall;
        bubble = !(fire && id_wreg);
    end

    // Tag pipeline shift and MUL/DIV scoreboard next state.
    always_comb begin
        tag_v_d     = {tag_v_q[DEPTH-2:0], 1'b0};
        tag_wreg_d  = {tag_wreg_q[DEPTH-2:0], 1'b0};
        tag_m2reg_d = {tag_m2reg_q[DEPTH-2:0], 1'b0};
        tag_rn_d[0] = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag_rn_d[i] = tag_rn_q[i-1];
        end
        if (fire && id_wreg) begin
            tag_v_d[0]     = 1'b1;
            tag_wreg_d[0]  = 1'b1;
            tag_m2reg_d[0] = id_m2reg;
            tag_rn_d[0]    = id_rn;
        end

        md_cnt_d = md_cnt_q;
        md_rn_d  = md_rn_q;
        if (fire && id_md_start) begin
            md_cnt_d = CW'(MD_LAT - 1);
            md_rn_d  = id_rn;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
        // Registered so the pulse lands in the cycle the count has reached zero.
        md_done_d = (md_cnt_q == CW'(1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_v_q     <= '0;
            tag_wreg_q  <= '0;
            tag_m2reg_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_rn_q[i] <= '0;
            end
            md_cnt_q  <= '0;
            md_rn_q   <= '0;
            md_done_q <= 1'b0;
        end else begin
            tag_v_q     <= tag_v_d;
            tag_wreg_q  <= tag_wreg_d;
            tag_m2reg_q <= tag_m2reg_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_rn_q[i] <= tag_rn_d[i];
            end
            md_cnt_q  <= md_cnt_d;
            md_rn_q   <= md_rn_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_done = md_done_q;
    assign md_rn   = md_rn_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where wpcir is low.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DEPTH=2, MD_LAT=4.
// Inputs are driven on the falling edge and outputs are checked 1 time unit later.
module tb_pipe_hazard_ctrl;

    logic       clock;
    logic       resetn;
    logic       id_valid, flush;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_md_start;
    logic [1:0] fwda, fwdb;
    logic       fwda_ld, fwdb_ld, wpcir, bubble, md_busy, md_done;
    logic [4:0] md_rn;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(2), .MD_LAT(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .id_valid    (id_valid),
        .flush       (flush),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wreg     (id_wreg),
        .id_m2reg    (id_m2reg),
        .id_rn       (id_rn),
        .id_md_start (id_md_start),
        .fwda        (fwda),
        .fwda_ld     (fwda_ld),
        .fwdb        (fwdb),
        .fwdb_ld     (fwdb_ld),
        .wpcir       (wpcir),
        .bubble      (bubble),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_rn       (md_rn)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One ID cycle: drive on the falling edge, settle, then the caller checks.
    task automatic cyc(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr, input logic m2,
                       input logic [4:0] rn, input logic md);
        @(negedge clock);
        id_valid    = v;
        flush       = fl;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_wreg     = wr;
        id_m2reg    = m2;
        id_rn       = rn;
        id_md_start = md;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        resetn      = 1'b0;
        id_valid    = 1'b0;
        flush       = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_wreg     = 1'b0;
        id_m2reg    = 1'b0;
        id_rn       = '0;
        id_md_start = 1'b0;
        #2;
        check("rst_fwda", 32'(fwda), 32'd0);
        check("rst_fwdb", 32'(fwdb), 32'd0);
        check("rst_ld", 32'({fwda_ld, fwdb_ld}), 32'd0);
        check("rst_wpcir", 32'(wpcir), 32'd1);
        check("rst_bubble", 32'(bubble), 32'd1);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_md_done", 32'(md_done), 32'd0);
        check("rst_md_rn", 32'(md_rn), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clock);
        resetn = 1'b1;

        // add r3,r1,r2 then add r4,r3,r3 back-to-back
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);
        check("add1_fwda", 32'(fwda), 32'd0);
        check("add1_bubble", 32'(bubble), 32'd0);
        cyc(1, 0, 5'd3, 5'd3, 1, 1, 1, 0, 5'd4, 0);
        check("b2b_fwda", 32'(fwda), 32'd1);
        check("b2b_fwdb", 32'(fwdb), 32'd1);
        check("b2b_ld", 32'({fwda_ld, fwdb_ld}), 32'd0);
        check("b2b_wpcir", 32'(wpcir), 32'd1);

        // add r3, gap, add r9,r3,r4 (r4 has left the tracked stages)
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0);
        idle();
        check("gap_bubble", 32'(bubble), 32'd1);
        check("gap_wpcir", 32'(wpcir), 32'd1);
        cyc(1, 0, 5'd3, 5'd4, 1, 1, 1, 0, 5'd9, 0);
        check("gap_fwda", 32'(fwda), 32'd2);
        check("gap_fwda_ld", 32'(fwda_ld), 32'd0);
        check("gap_fwdb", 32'(fwdb), 32'd0);

        // lw r5 then add r6,r5,r1: one stall, then forward from MEM with load data
        cyc(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5, 0);
        cyc(1, 0, 5'd5, 5'd1, 1, 1, 1, 0, 5'd6, 0);
        check("lu_wpcir", 32'(wpcir), 32'd0);
        check("lu_bubble", 32'(bubble), 32'd1);
        check("lu_fwda", 32'(fwda), 32'd0);
        cyc(1, 0, 5'd5, 5'd1, 1, 1, 1, 0, 5'd6, 0);
        check("lu2_wpcir", 32'(wpcir), 32'd1);
        check("lu2_fwda", 32'(fwda), 32'd2);
        check("lu2_fwda_ld", 32'(fwda_ld), 32'd1);
        check("lu2_bubble", 32'(bubble), 32'd0);

        // writes to r0 (ALU then load), then read r0: no forward, no stall
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd0, 0);
        cyc(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0, 0);
        cyc(1, 0, 5'd0, 5'd0, 1, 1, 1, 0, 5'd10, 0);
        check("r0_fwda", 32'(fwda), 32'd0);
        check("r0_fwdb", 32'(fwdb), 32'd0);
        check("r0_wpcir", 32'(wpcir), 32'd1);

        // load-use hazard with flush: flush wins
        cyc(1, 0, 5'd1, 5'd0, 1, 0, 1, 1, 5'd11, 0);
        cyc(1, 1, 5'd11, 5'd11, 1, 1, 1, 0, 5'd12, 0);
        check("fl_wpcir", 32'(wpcir), 32'd1);
        check("fl_bubble", 32'(bubble), 32'd1);

        // mul r7 then add r8,r7,r0: three stall cycles, md_done four cycles after issue
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd7, 1);
        check("mul_wpcir", 32'(wpcir), 32'd1);
        check("mul_busy0", 32'(md_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 5'd7, 5'd0, 1, 1, 1, 0, 5'd8, 0);
            check("raw_wpcir", 32'(wpcir), 32'd0);
            check("raw_busy", 32'(md_busy), 32'd1);
            check("raw_md_rn", 32'(md_rn), 32'd7);
            check("raw_done", 32'(md_done), 32'd0);
        end
        cyc(1, 0, 5'd7, 5'd0, 1, 1, 1, 0, 5'd8, 0);
        check("raw_end_busy", 32'(md_busy), 32'd0);
        check("raw_end_done", 32'(md_done), 32'd1);
        check("raw_end_wpcir", 32'(wpcir), 32'd1);
        check("raw_end_fwda", 32'(fwda), 32'd0);

        // mul r13, then structural (mul r14) and WAW (add r13) stalls
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd13, 1);
        check("mul2_wpcir", 32'(wpcir), 32'd1);
        check("mul2_done", 32'(md_done), 32'd0);
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd14, 1);
        check("struct_wpcir", 32'(wpcir), 32'd0);
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd13, 0);
        check("waw_wpcir", 32'(wpcir), 32'd0);
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd14, 1);
        check("struct2_wpcir", 32'(wpcir), 32'd0);
        cyc(1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd14, 1);
        check("mul3_done", 32'(md_done), 32'd1);
        check("mul3_wpcir", 32'(wpcir), 32'd1);
        idle();
        check("mul3_busy", 32'(md_busy), 32'd1);
        check("mul3_md_rn", 32'(md_rn), 32'd14);
`ifdef HAZ_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd7);
`endif

        // reset mid-operation aborts the MUL/DIV without a done pulse
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(md_busy), 32'd0);
        check("abort_md_rn", 32'(md_rn), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            check("abort_no_done", 32'(md_done), 32'd0);
            check("abort_idle_busy", 32'(md_busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
